// File: rtl/edge_detect_pkg.sv
// Shared state types for the per-channel edge detector FSMs.
// Binary encodings are fixed so the unused Moore code (2'd3) is well defined.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    EDGE = 2'd1,
    ONE  = 2'd2
  } moore_state_e;

  typedef enum logic {
    M_ZERO = 1'b0,
    M_ONE  = 1'b1
  } mealy_state_e;

endpackage

// File: rtl/edge_detect_pair_if.sv
// Level inputs and the two tick outputs for all channels, bundled as one interface.
interface edge_detect_pair_if #(
  parameter int N_CH = 1
);

  logic [N_CH-1:0] level;
  logic [N_CH-1:0] tick_mealy;
  logic [N_CH-1:0] tick_moore;

  modport master (
    output level,
    input  tick_mealy,
    input  tick_moore
  );

  modport slave (
    input  level,
    output tick_mealy,
    output tick_moore
  );

endinterface

// File: rtl/edge_detect_ch.sv
// One channel: a 3-state Moore detector (registered tick) and a 2-state Mealy
// detector (zero-latency tick), both driven from the same level input.
import edge_detect_pkg::*;

module edge_detect_ch (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic tick_mealy,
  output logic tick_moore
);

  moore_state_e moore_state;
  moore_state_e moore_next;
  mealy_state_e mealy_state;
  mealy_state_e mealy_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      moore_state <= ZERO;
      mealy_state <= M_ZERO;
    end else begin
      moore_state <= moore_next;
      mealy_state <= mealy_next;
    end
  end

  // The unused Moore code falls back to ZERO
  always_comb begin
    moore_next = ZERO;
    case (moore_state)
      ZERO:    moore_next = level ? EDGE : ZERO;
      EDGE:    moore_next = level ? ONE  : ZERO;
      ONE:     moore_next = level ? ONE  : ZERO;
      default: moore_next = ZERO;
    endcase
  end

  always_comb begin
    mealy_next = M_ZERO;
    case (mealy_state)
      M_ZERO:  mealy_next = level ? M_ONE : M_ZERO;
      M_ONE:   mealy_next = level ? M_ONE : M_ZERO;
      default: mealy_next = M_ZERO;
    endcase
  end

  // The Mealy tick is gated by rst so it stays quiet while reset is held
  always_comb begin
    tick_moore = (moore_state == EDGE);
    tick_mealy = rst && (mealy_state == M_ZERO) && level;
  end

endmodule

// File: rtl/edge_detect_pair.sv
// Top level: N_CH independent edge_detect_ch instances, one per level bit.
import edge_detect_pkg::*;

module edge_detect_pair #(
  parameter int N_CH = 1
) (
  input logic             clk,
  input logic             rst,
  edge_detect_pair_if.slave bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_detect_ch u_ch (
      .clk        (clk),
      .rst        (rst),
      .level      (bus.level[i]),
      .tick_mealy (bus.tick_mealy[i]),
      .tick_moore (bus.tick_moore[i])
    );
  end

endmodule

// File: tb/tb_edge_detect_pair.sv
// Randomized and directed checks of edge_detect_pair against a sample-history model.
module tb_edge_detect_pair;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int passes = 0;

  // Model: effective sample at each rising edge is (rst & level); a channel
  // is "high" when its last effective sample was 1.
  logic [N-1:0] s_cur  = '0;
  logic [N-1:0] s_prev = '0;

  edge_detect_pair_if #(.N_CH(N)) bus_if ();

  edge_detect_pair #(.N_CH(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [N-1:0] got,
                              input logic [N-1:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    else
      passes++;
  endtask

  function automatic logic [N-1:0] mealy_exp(input logic r, input logic [N-1:0] lvl);
    return r ? (lvl & ~s_cur) : '0;
  endfunction

  // One clock cycle: level=a just after the falling edge, level=b shortly before
  // the rising edge (b is what gets sampled), then a check just after the edge.
  task automatic apply_stimulus(input logic r, input logic [N-1:0] a,
                                input logic [N-1:0] b);
    @(negedge clk);
    rst = r;
    bus_if.level = a;
    #1;
    check_output("moore", bus_if.tick_moore, s_cur & ~s_prev);
    check_output("mealy_a", bus_if.tick_mealy, mealy_exp(r, a));
    #1;
    bus_if.level = b;
    #1;
    check_output("mealy_b", bus_if.tick_mealy, mealy_exp(r, b));
    @(posedge clk);
    s_prev = s_cur;
    s_cur  = r ? b : '0;
    #1;
    check_output("mealy_post", bus_if.tick_mealy, mealy_exp(r, b));
    check_output("moore_post", bus_if.tick_moore, s_cur & ~s_prev);
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         r;
    bus_if.level = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Reset hold with level high, then release: both ticks fire
    apply_stimulus(1'b0, 4'hF, 4'hF);
    apply_stimulus(1'b0, 4'hF, 4'hF);
    apply_stimulus(1'b1, 4'hF, 4'hF);
    apply_stimulus(1'b1, 4'hF, 4'hF);

    // Single-cycle level, then held level for 5 cycles
    repeat (3) apply_stimulus(1'b1, 4'h0, 4'h0);
    apply_stimulus(1'b1, 4'hF, 4'hF);
    apply_stimulus(1'b1, 4'h0, 4'h0);
    apply_stimulus(1'b1, 4'h0, 4'h0);
    repeat (5) apply_stimulus(1'b1, 4'hF, 4'hF);
    apply_stimulus(1'b1, 4'h0, 4'h0);

    // Sub-cycle pulse: high after falling edge, low before rising edge
    apply_stimulus(1'b1, 4'hF, 4'h0);
    apply_stimulus(1'b1, 4'h0, 4'h0);

    // Re-trigger 1,0,1
    apply_stimulus(1'b1, 4'hF, 4'hF);
    apply_stimulus(1'b1, 4'h0, 4'h0);
    apply_stimulus(1'b1, 4'hF, 4'hF);
    apply_stimulus(1'b1, 4'h0, 4'h0);

    // Multi-channel: 0101 then 1111 gives moore 0101 then 1010
    apply_stimulus(1'b1, 4'h0, 4'h0);
    apply_stimulus(1'b1, 4'h5, 4'h5);
    apply_stimulus(1'b1, 4'hF, 4'hF);
    apply_stimulus(1'b1, 4'hF, 4'hF);

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) != 0);
      a = N'($urandom);
      b = ($urandom_range(0, 3) == 0) ? N'($urandom) : a;
      apply_stimulus(r, a, b);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/edge_detect_pair.md
Name: edge_detect_pair

Overview:
- Per-channel rising-edge detector that produces two forms of the same event from one level input.
- tick_moore is a registered, glitch-free one-cycle pulse built from a 3-state Moore FSM.
- tick_mealy is an immediate pulse built from a 2-state Mealy FSM and decoded combinationally from level.
- Used by upstream control logic to turn slow or held levels into single-event strobes.

Parameters:
- N_CH, 1, number of independent channels; each channel has its own pair of FSMs.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low: asserted when 0 and sampled only on a clk rising edge.
- level  input  N_CH  level input per channel; the FSMs act on the value sampled at each clk rising edge.
- tick_mealy  output  N_CH  Mealy edge pulse per channel, combinational from level and state.
- tick_moore  output  N_CH  Moore edge pulse per channel, decoded from registered state only.

Behaviour:
- Reset: while rst==0 at a clk rising edge, every channel goes to state ZERO.
- After that reset edge, tick_moore is 0.
- tick_mealy is forced to 0 whenever rst==0 (combinational gate).
- Moore FSM, per channel, states ZERO, EDGE, ONE:
  - ZERO: level=1 goes to EDGE; otherwise stays in ZERO.
  - EDGE: level=1 goes to ONE; level=0 goes to ZERO.
  - ONE: level=1 stays in ONE; level=0 goes to ZERO.
  - tick_moore = (state==EDGE). It rises one clock edge after level is first sampled high and lasts exactly one clk period.
  - A level held high for K≥1 sampled edges gives exactly one pulse.
  - A level high for exactly one sample gives one pulse (EDGE, then ZERO).
- Mealy FSM, per channel, states ZERO, ONE:
  - ZERO: level=1 goes to ONE.
  - ONE: level=0 goes to ZERO.
  - tick_mealy = rst & (state==ZERO) & level, with zero latency.
  - Pulse width runs from level rising to the next clk rising edge, or to level falling if earlier.
  - A level pulse that rises and falls between two clock edges still produces a tick_mealy glitch pulse; tick_moore stays 0.
- Leaving reset with level already high counts as a rising edge on both outputs.
- Channels are fully independent; there is no cross-channel interaction.
- A level that returns high one cycle after falling (1,0,1 samples) produces a new pulse on both outputs.
- State encoding is binary; unused encodings go to ZERO with outputs 0.
- No X propagation: if level is X, the bench must not rely on outputs until level is driven.

Decomposition:
- Package edge_detect_pkg:
  - typedef enum moore_state_e {ZERO, EDGE, ONE}
  - typedef enum mealy_state_e {M_ZERO, M_ONE}
- Sub-module edge_detect_ch: one channel containing both FSMs.
- Top module: generate loop instantiating N_CH copies of edge_detect_ch.

Test Plan:
- Reset hold: rst=0 for 2 cycles with level=1 → tick_moore=0 and tick_mealy=0 throughout; at the first edge after rst=1, both outputs pulse.
- Single-cycle level: level=0 for 3 cycles, then 1 from just after a falling clk edge for one cycle, then 0.
  - tick_mealy rises immediately with level and falls at the next rising edge.
  - tick_moore is 1 for exactly the following clk period.
- Held level: level=1 for 5 cycles → exactly one tick_moore pulse (cycle after first sample) and one tick_mealy pulse; both 0 while in ONE.
- Sub-cycle pulse: level high from falling edge to just before the next rising edge → tick_mealy half-cycle pulse; tick_moore stays 0; state stays ZERO.
- Re-trigger: level samples 1,0,1 → two tick_moore pulses, two cycles apart.
- Multi-channel (N_CH=4): level=4'b0101, then 4'b1111 → tick_moore is 4'b0101 the cycle after the first sample, then 4'b1010 one cycle later.
